sram_wb_arbiter: RTL and testbench
==================================

Name: sram_wb_arbiter

Overview:
- Sequences and shares the two 32x512 SRAM banks between two requesters: the Wishbone slave port (management SoC) and a logic-analyzer-driven port (LA).
- Single-port access (port 0, 1rw) per transaction: address decode to bank, active-low chip select/write enable generation, fixed read-latency wait, response/ack generation.
- Sits in the user project wrapper between the Wishbone/LA buses and the SRAM macros; round-robin arbitration, one transaction in flight.

Parameters:
- ADDR_W, 9, word address width per bank (512 words).
- DATA_W, 32, data width.
- BASE_ADDR, 32'h3000_0000, Wishbone base; bits [31:ADDR_W+3] must match.
- READ_LAT, 1, SRAM clock edges from csb-low cycle to dout valid (range 1..4).

Ports:
- wb_clk_i  in  1  sole clock; SRAM clk0 tied to it externally.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address; word = [ADDR_W+1:2], bank = [ADDR_W+2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle ack.
- wbs_dat_o  out  32  read data, valid with ack.
- la_req_i  in  1  LA request (level, held until grant).
- la_we_i  in  1  LA write.
- la_adr_i  in  ADDR_W+1  MSB = bank.
- la_dat_i  in  32  LA write data; full-word writes (wmask 4'hF).
- la_gnt_o  out  1  one-cycle grant pulse.
- la_rvalid_o  out  1  one-cycle read-data valid.
- la_rdata_o  out  32  LA read data.
- sram_csb0_o  out  2  per-bank chip select, active-low.
- sram_web0_o  out  1  write enable, active-low.
- sram_wmask0_o  out  4  byte mask.
- sram_addr0_o  out  ADDR_W  word address.
- sram_din0_o  out  32  write data.
- sram_dout0_i  in  64  {bank1, bank0} read data.

Behaviour:
- Reset values (all registered outputs): csb 2'b11, web 1, wmask 0, addr 0, din 0, ack 0, dat_o 0, gnt 0, rvalid 0, rdata 0, state IDLE, rr pointer = WB priority.
- FSM states:
  - IDLE: wb_req = cyc & stb & ~ack_o. If any request exists, the arbiter picks one, captures the command, and moves to ISSUE.
  - ISSUE: one cycle. Selected csb bit low; web = ~we.
  - WAIT: reads only; lasts READ_LAT cycles, csb high. On the last WAIT edge, capture dout of the latched bank.
  - RESP: one cycle. WB: ack = 1 with dat_o. LA: rvalid = 1 on reads only. Then IDLE.
  - Writes go ISSUE -> RESP.
- Latency from request sampled in IDLE: write ack 2 cycles; read ack 2+READ_LAT cycles.
- la_gnt_o pulses in the ISSUE cycle. LA writes get no RESP pulse (the grant is the completion); their RESP cycle is idle.
- Round-robin: with both requesting, grant goes to the requester not granted last. A lone requester always wins.
- WB address outside BASE_ADDR window: no SRAM access; IDLE -> RESP directly, ack with dat_o = 0.
- WB cyc dropped after capture: SRAM access completes, ack suppressed; still return via RESP -> IDLE.
- wbs_sel_i = 0 write: issued, wmask 0, acked normally.
- Reset mid-transaction: immediate return to IDLE on the next edge, csb forced 2'b11, no ack/rvalid.
- Wrap-around: word address 511 of bank 0 and word 0 of bank 1 are contiguous byte addresses; no special handling.

Optional Feature:
- SRAM_WB_ARB_STATS_EN defined: adds outputs wb_grant_cnt_o[15:0] and la_grant_cnt_o[15:0].
  - Each increments on its requester's ISSUE cycle and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package sram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP).
  - requester enum (REQ_WB, REQ_LA).
  - NBANK = 2 and BANK_SEL_BIT localparam.
  - Command struct {we, bank, addr, sel, data, req_id}.
- Sub-module rr_arbiter2: 2-input round-robin with grant-update strobe, purely sequential pointer.

Test Plan:
- WB write 32'hDEADBEEF to 0x3000_0010, sel 4'hF -> ISSUE cycle: csb 2'b10, web 0, addr 4, din DEADBEEF; ack 2 cycles after stb.
- WB read 0x3000_0810 (bank 1, word 4), dout bank1 = 32'hCAFEF00D, READ_LAT=1 -> csb 2'b01, ack at cycle 3, dat_o CAFEF00D.
- WB and LA request the same cycle, both 4 times (back-to-back) -> grants alternate WB, LA, WB, LA; no cycle with both csb bits low.
- WB read at 0x2000_0000 -> no csb low, ack 1 cycle after request with dat_o 0.
- LA read, reset asserted during WAIT -> next edge csb 2'b11, rvalid never pulses, state IDLE.
- With SRAM_WB_ARB_STATS_EN: 3 WB writes and 2 LA reads -> wb_grant_cnt_o = 3, la_grant_cnt_o = 2.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM Wishbone/LA arbiter: FSM states, requester ids,
// bank geometry and the captured command record.
package sram_arb_pkg;

   localparam int CMD_ADDR_W   = 9;
   localparam int CMD_DATA_W   = 32;
   localparam int NBANK        = 2;
   localparam int BANK_SEL_BIT = CMD_ADDR_W + 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      REQ_WB,
      REQ_LA
   } req_t;

   typedef struct packed {
      logic                  we;
      logic                  bank;
      logic [CMD_ADDR_W-1:0] addr;
      logic [3:0]            sel;
      logic [CMD_DATA_W-1:0] data;
      req_t                  req_id;
   } cmd_t;

endpackage

// File: rtl/sram_wb_arbiter_rr.sv
// rr_arbiter2: two-way round-robin picker. The grant is combinational from the
// requests; only the last-granted pointer is state, moved on i_update.
module rr_arbiter2
   import sram_arb_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_reqWb,
   input  logic i_reqLa,
   input  logic i_update,
   output logic o_valid,
   output req_t o_grant
);

   req_t r_last;

   // Reset to "LA granted last" so Wishbone wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= REQ_LA;
      end else if (i_update && o_valid) begin
         r_last <= o_grant;
      end
   end

   always_comb begin
      o_valid = i_reqWb | i_reqLa;
      o_grant = REQ_WB;
      if (i_reqWb && i_reqLa) begin
         o_grant = (r_last == REQ_WB) ? REQ_LA : REQ_WB;
      end else if (i_reqLa) begin
         o_grant = REQ_LA;
      end
   end

endmodule

// File: rtl/sram_wb_arbiter.sv
// sram_wb_arbiter: sequences one transaction at a time from Wishbone or LA onto two SRAM banks.
// Define SRAM_WB_ARB_STATS_EN to add saturating per-requester grant counters.
module sram_wb_arbiter
   import sram_arb_pkg::*;
#(
   parameter int          ADDR_W    = CMD_ADDR_W,
   parameter int          DATA_W    = CMD_DATA_W,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          READ_LAT  = 1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [DATA_W-1:0]   wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [DATA_W-1:0]   wbs_dat_o,
   input  logic                la_req_i,
   input  logic                la_we_i,
   input  logic [ADDR_W:0]     la_adr_i,
   input  logic [DATA_W-1:0]   la_dat_i,
   output logic                la_gnt_o,
   output logic                la_rvalid_o,
   output logic [DATA_W-1:0]   la_rdata_o,
   output logic [NBANK-1:0]    sram_csb0_o,
   output logic                sram_web0_o,
   output logic [3:0]          sram_wmask0_o,
   output logic [ADDR_W-1:0]   sram_addr0_o,
   output logic [DATA_W-1:0]   sram_din0_o,
   input  logic [2*DATA_W-1:0] sram_dout0_i
`ifdef SRAM_WB_ARB_STATS_EN
   ,
   output logic [15:0]         wb_grant_cnt_o,
   output logic [15:0]         la_grant_cnt_o
`endif
);

   localparam int BANK_BIT = ADDR_W + 2;
   localparam int TAG_LSB  = ADDR_W + 3;

   state_t              r_state, w_stateNext;
   cmd_t                r_cmd, w_cmdNext;
   logic [1:0]          r_waitCnt, w_waitCntNext;
   logic                r_cycAlive, w_cycAliveNext;
   logic                w_wbReq, w_arbValid, w_arbUpdate, w_inWindow;
   req_t                w_arbGrant;
   logic [DATA_W-1:0]   w_bankDout;
   logic [NBANK-1:0]    w_csbNext;
   logic                w_webNext, w_ackNext, w_gntNext, w_rvalidNext;
   logic [3:0]          w_wmaskNext;
   logic [ADDR_W-1:0]   w_addrNext;
   logic [DATA_W-1:0]   w_dinNext, w_datNext, w_rdataNext;
   logic                w_unused;

   // Masking with our own ack keeps a classic master's held strobe from re-requesting in RESP.
   assign w_wbReq    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign w_inWindow = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign w_bankDout = r_cmd.bank ? sram_dout0_i[2*DATA_W-1:DATA_W] : sram_dout0_i[DATA_W-1:0];
   assign w_unused   = ^wbs_adr_i[1:0];

   rr_arbiter2 u_arb (
      .i_clk    (wb_clk_i),
      .i_rst    (wb_rst_i),
      .i_reqWb  (w_wbReq),
      .i_reqLa  (la_req_i),
      .i_update (w_arbUpdate),
      .o_valid  (w_arbValid),
      .o_grant  (w_arbGrant)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state       <= IDLE;
         r_cmd         <= '0;
         r_waitCnt     <= '0;
         r_cycAlive    <= 1'b0;
         sram_csb0_o   <= '1;
         sram_web0_o   <= 1'b1;
         sram_wmask0_o <= '0;
         sram_addr0_o  <= '0;
         sram_din0_o   <= '0;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         la_gnt_o      <= 1'b0;
         la_rvalid_o   <= 1'b0;
         la_rdata_o    <= '0;
      end else begin
         r_state       <= w_stateNext;
         r_cmd         <= w_cmdNext;
         r_waitCnt     <= w_waitCntNext;
         r_cycAlive    <= w_cycAliveNext;
         sram_csb0_o   <= w_csbNext;
         sram_web0_o   <= w_webNext;
         sram_wmask0_o <= w_wmaskNext;
         sram_addr0_o  <= w_addrNext;
         sram_din0_o   <= w_dinNext;
         wbs_ack_o     <= w_ackNext;
         wbs_dat_o     <= w_datNext;
         la_gnt_o      <= w_gntNext;
         la_rvalid_o   <= w_rvalidNext;
         la_rdata_o    <= w_rdataNext;
      end
   end

   // Outputs are registered, so each state computes what the *next* cycle must show.
   always_comb begin
      w_stateNext    = r_state;
      w_cmdNext      = r_cmd;
      w_waitCntNext  = r_waitCnt;
      w_cycAliveNext = r_cycAlive & wbs_cyc_i;
      w_arbUpdate    = 1'b0;
      w_csbNext      = '1;
      w_webNext      = 1'b1;
      w_wmaskNext    = r_cmd.sel;
      w_addrNext     = r_cmd.addr;
      w_dinNext      = r_cmd.data;
      w_ackNext      = 1'b0;
      w_datNext      = wbs_dat_o;
      w_gntNext      = 1'b0;
      w_rvalidNext   = 1'b0;
      w_rdataNext    = la_rdata_o;
      case (r_state)
         IDLE: begin
            if (w_arbValid) begin
               w_arbUpdate    = 1'b1;
               w_cycAliveNext = 1'b1;
               if (w_arbGrant == REQ_WB) begin
                  w_cmdNext.we     = wbs_we_i;
                  w_cmdNext.bank   = wbs_adr_i[BANK_BIT];
                  w_cmdNext.addr   = wbs_adr_i[ADDR_W+1:2];
                  w_cmdNext.sel    = wbs_sel_i;
                  w_cmdNext.data   = wbs_dat_i;
                  w_cmdNext.req_id = REQ_WB;
               end else begin
                  w_cmdNext.we     = la_we_i;
                  w_cmdNext.bank   = la_adr_i[ADDR_W];
                  w_cmdNext.addr   = la_adr_i[ADDR_W-1:0];
                  w_cmdNext.sel    = 4'hF;
                  w_cmdNext.data   = la_dat_i;
                  w_cmdNext.req_id = REQ_LA;
               end
               if (w_arbGrant == REQ_WB && !w_inWindow) begin
                  w_stateNext = RESP;
                  w_ackNext   = 1'b1;
                  w_datNext   = '0;
               end else begin
                  w_stateNext                = ISSUE;
                  w_csbNext[w_cmdNext.bank] = 1'b0;
                  w_webNext                  = ~w_cmdNext.we;
                  w_wmaskNext                = w_cmdNext.sel;
                  w_addrNext                 = w_cmdNext.addr;
                  w_dinNext                  = w_cmdNext.data;
                  w_gntNext                  = (w_arbGrant == REQ_LA);
               end
            end
         end
         ISSUE: begin
            w_waitCntNext = '0;
            if (r_cmd.we) begin
               w_stateNext = RESP;
               w_ackNext   = (r_cmd.req_id == REQ_WB) && w_cycAliveNext;
            end else begin
               w_stateNext = WAIT;
            end
         end
         WAIT: begin
            if (r_waitCnt == 2'(READ_LAT - 1)) begin
               w_stateNext = RESP;
               if (r_cmd.req_id == REQ_WB) begin
                  w_ackNext = w_cycAliveNext;
                  if (w_cycAliveNext) begin
                     w_datNext = w_bankDout;
                  end
               end else begin
                  w_rvalidNext = 1'b1;
                  w_rdataNext  = w_bankDout;
               end
            end else begin
               w_waitCntNext = r_waitCnt + 2'd1;
            end
         end
         RESP: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

`ifdef SRAM_WB_ARB_STATS_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_grant_cnt_o <= '0;
         la_grant_cnt_o <= '0;
      end else if (r_state == ISSUE) begin
         if (r_cmd.req_id == REQ_WB && wb_grant_cnt_o != 16'hFFFF) begin
            wb_grant_cnt_o <= wb_grant_cnt_o + 16'd1;
         end
         if (r_cmd.req_id == REQ_LA && la_grant_cnt_o != 16'hFFFF) begin
            la_grant_cnt_o <= la_grant_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed self-checking bench for sram_wb_arbiter with a latency-1 two-bank SRAM model.
// Build with SRAM_WB_ARB_STATS_EN defined to also exercise the grant counters.
module tb_sram_wb_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        wbs_ack_o;
   logic        la_req_i, la_we_i, la_gnt_o, la_rvalid_o;
   logic [9:0]  la_adr_i;
   logic [31:0] la_dat_i, la_rdata_o;
   logic [1:0]  sram_csb0_o;
   logic        sram_web0_o;
   logic [3:0]  sram_wmask0_o;
   logic [8:0]  sram_addr0_o;
   logic [31:0] sram_din0_o;
   logic [63:0] sramDout;
`ifdef SRAM_WB_ARB_STATS_EN
   logic [15:0] wb_grant_cnt_o, la_grant_cnt_o;
`endif

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] mem [2][512];
   logic        preEn = 1'b0;
   logic        preBank;
   logic [8:0]  preAddr;
   logic [31:0] preData;

   int issueCount   = 0;
   int bothLowCount = 0;
   int logLen       = 0;
   logic issueLog [64];

   always #5 clock = ~clock;

   sram_wb_arbiter dut (
      .wb_clk_i      (clock),
      .wb_rst_i      (reset),
      .wbs_cyc_i     (wbs_cyc_i),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_we_i      (wbs_we_i),
      .wbs_sel_i     (wbs_sel_i),
      .wbs_adr_i     (wbs_adr_i),
      .wbs_dat_i     (wbs_dat_i),
      .wbs_ack_o     (wbs_ack_o),
      .wbs_dat_o     (wbs_dat_o),
      .la_req_i      (la_req_i),
      .la_we_i       (la_we_i),
      .la_adr_i      (la_adr_i),
      .la_dat_i      (la_dat_i),
      .la_gnt_o      (la_gnt_o),
      .la_rvalid_o   (la_rvalid_o),
      .la_rdata_o    (la_rdata_o),
      .sram_csb0_o   (sram_csb0_o),
      .sram_web0_o   (sram_web0_o),
      .sram_wmask0_o (sram_wmask0_o),
      .sram_addr0_o  (sram_addr0_o),
      .sram_din0_o   (sram_din0_o),
      .sram_dout0_i  (sramDout)
`ifdef SRAM_WB_ARB_STATS_EN
      ,
      .wb_grant_cnt_o (wb_grant_cnt_o),
      .la_grant_cnt_o (la_grant_cnt_o)
`endif
   );

   // SRAM model: samples csb/web on the clock edge, read data valid one edge later.
   always @(posedge clock) begin
      sramDout <= {2{32'h5A5A_5A5A}};
      if (preEn) mem[preBank][preAddr] <= preData;
      for (int b = 0; b < 2; b++) begin
         if (!sram_csb0_o[b]) begin
            if (!sram_web0_o) begin
               for (int k = 0; k < 4; k++)
                  if (sram_wmask0_o[k]) mem[b][sram_addr0_o][8*k +: 8] <= sram_din0_o[8*k +: 8];
            end else begin
               sramDout[32*b +: 32] <= mem[b][sram_addr0_o];
            end
         end
      end
   end

   always @(negedge clock) begin
      if (sram_csb0_o != 2'b11) begin
         issueCount = issueCount + 1;
         if (logLen < 64) begin
            issueLog[logLen] = la_gnt_o;
            logLen = logLen + 1;
         end
      end
      if (sram_csb0_o == 2'b00) bothLowCount = bothLowCount + 1;
   end

   task automatic clearInputs();
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 4'h0;
      wbs_adr_i = '0; wbs_dat_i = '0;
      la_req_i = 0; la_we_i = 0; la_adr_i = '0; la_dat_i = '0;
   endtask

   task automatic preload(input logic b, input logic [8:0] a, input logic [31:0] d);
      @(posedge clock); #1;
      preBank = b; preAddr = a; preData = d; preEn = 1'b1;
      @(posedge clock); #1;
      preEn = 1'b0;
   endtask

   task automatic resetDut();
      @(posedge clock); #1;
      reset = 1'b1; clearInputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clearInputs();
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0010; la_req_i = 1;
      repeat (3) @(posedge clock);
      #1;
      assertCount++; if (sram_csb0_o !== 2'b11) begin failCount++; $display("[TB] FAIL reset_csb: got %b expected 11", sram_csb0_o); end
      assertCount++; if (sram_web0_o !== 1'b1) begin failCount++; $display("[TB] FAIL reset_web: got %b expected 1", sram_web0_o); end
      assertCount++; if (sram_wmask0_o !== 4'h0) begin failCount++; $display("[TB] FAIL reset_wmask: got %h expected 0", sram_wmask0_o); end
      assertCount++; if (sram_addr0_o !== 9'd0) begin failCount++; $display("[TB] FAIL reset_addr: got %h expected 0", sram_addr0_o); end
      assertCount++; if (sram_din0_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_din: got %h expected 0", sram_din0_o); end
      assertCount++; if (wbs_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ack: got %b expected 0", wbs_ack_o); end
      assertCount++; if (wbs_dat_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_dat: got %h expected 0", wbs_dat_o); end
      assertCount++; if (la_gnt_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_gnt: got %b expected 0", la_gnt_o); end
      assertCount++; if (la_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rvalid: got %b expected 0", la_rvalid_o); end
      assertCount++; if (la_rdata_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", la_rdata_o); end
      clearInputs();
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_wb_write();
      int ackCycle = 0;
      @(posedge clock); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3000_0010; wbs_dat_i = 32'hDEAD_BEEF;
      for (int c = 1; c <= 6 && ackCycle == 0; c++) begin
         @(posedge clock); #1;
         if (c == 1) begin
            assertCount++; if (sram_csb0_o !== 2'b10) begin failCount++; $display("[TB] FAIL wr_csb: got %b expected 10", sram_csb0_o); end
            assertCount++; if (sram_web0_o !== 1'b0) begin failCount++; $display("[TB] FAIL wr_web: got %b expected 0", sram_web0_o); end
            assertCount++; if (sram_addr0_o !== 9'd4) begin failCount++; $display("[TB] FAIL wr_addr: got %0d expected 4", sram_addr0_o); end
            assertCount++; if (sram_din0_o !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL wr_din: got %h expected deadbeef", sram_din0_o); end
            assertCount++; if (sram_wmask0_o !== 4'hF) begin failCount++; $display("[TB] FAIL wr_wmask: got %h expected f", sram_wmask0_o); end
         end
         if (wbs_ack_o) ackCycle = c;
      end
      clearInputs();
      assertCount++; if (ackCycle != 2) begin failCount++; $display("[TB] FAIL wr_ack_latency: got %0d expected 2", ackCycle); end
      assertCount++; if (mem[0][4] !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL wr_mem: got %h expected deadbeef", mem[0][4]); end
      @(posedge clock); #1;
      assertCount++; if (wbs_ack_o !== 1'b0) begin failCount++; $display("[TB] FAIL wr_ack_single: got %b expected 0", wbs_ack_o); end
   endtask

   task automatic test_wb_read();
      int ackCycle = 0;
      logic [31:0] datSeen = '0;
      preload(1'b1, 9'd4, 32'hCAFE_F00D);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0810;
      for (int c = 1; c <= 8 && ackCycle == 0; c++) begin
         @(posedge clock); #1;
         if (c == 1) begin
            assertCount++; if (sram_csb0_o !== 2'b01) begin failCount++; $display("[TB] FAIL rd_csb: got %b expected 01", sram_csb0_o); end
            assertCount++; if (sram_web0_o !== 1'b1) begin failCount++; $display("[TB] FAIL rd_web: got %b expected 1", sram_web0_o); end
            assertCount++; if (sram_addr0_o !== 9'd4) begin failCount++; $display("[TB] FAIL rd_addr: got %0d expected 4", sram_addr0_o); end
         end
         if (c == 2) begin
            assertCount++; if (sram_csb0_o !== 2'b11) begin failCount++; $display("[TB] FAIL rd_wait_csb: got %b expected 11", sram_csb0_o); end
         end
         if (wbs_ack_o) begin ackCycle = c; datSeen = wbs_dat_o; end
      end
      clearInputs();
      assertCount++; if (ackCycle != 3) begin failCount++; $display("[TB] FAIL rd_ack_latency: got %0d expected 3", ackCycle); end
      assertCount++; if (datSeen !== 32'hCAFE_F00D) begin failCount++; $display("[TB] FAIL rd_data: got %h expected cafef00d", datSeen); end
   endtask

   task automatic test_out_of_window();
      int ackCycle = 0;
      int issuesBefore;
      logic [31:0] datSeen = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      issuesBefore = issueCount;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h2000_0000;
      for (int c = 1; c <= 6 && ackCycle == 0; c++) begin
         @(posedge clock); #1;
         if (wbs_ack_o) begin ackCycle = c; datSeen = wbs_dat_o; end
      end
      clearInputs();
      @(posedge clock); #1;
      assertCount++; if (ackCycle != 1) begin failCount++; $display("[TB] FAIL oow_ack_latency: got %0d expected 1", ackCycle); end
      assertCount++; if (datSeen !== 32'h0) begin failCount++; $display("[TB] FAIL oow_data: got %h expected 0", datSeen); end
      assertCount++; if (issueCount != issuesBefore) begin failCount++; $display("[TB] FAIL oow_no_access: got %0d csb-low cycles expected 0", issueCount - issuesBefore); end
   endtask

   task automatic test_la_read();
      int rvCycle = 0;
      int gntCycle = 0;
      logic [31:0] dataSeen = '0;
      preload(1'b0, 9'd7, 32'h1234_5678);
      la_req_i = 1; la_we_i = 0; la_adr_i = {1'b0, 9'd7};
      for (int c = 1; c <= 8 && rvCycle == 0; c++) begin
         @(posedge clock); #1;
         if (la_gnt_o) begin
            if (gntCycle == 0) gntCycle = c;
            la_req_i = 0;
            assertCount++; if (sram_csb0_o !== 2'b10) begin failCount++; $display("[TB] FAIL la_rd_csb: got %b expected 10", sram_csb0_o); end
         end
         if (la_rvalid_o) begin rvCycle = c; dataSeen = la_rdata_o; end
      end
      clearInputs();
      assertCount++; if (gntCycle != 1) begin failCount++; $display("[TB] FAIL la_rd_gnt_cycle: got %0d expected 1", gntCycle); end
      assertCount++; if (rvCycle != 3) begin failCount++; $display("[TB] FAIL la_rd_rvalid_cycle: got %0d expected 3", rvCycle); end
      assertCount++; if (dataSeen !== 32'h1234_5678) begin failCount++; $display("[TB] FAIL la_rd_data: got %h expected 12345678", dataSeen); end
   endtask

   task automatic test_la_write();
      int gntCycle = 0;
      int rvSeen = 0;
      @(posedge clock); #1;
      la_req_i = 1; la_we_i = 1; la_adr_i = {1'b1, 9'd9}; la_dat_i = 32'h0A0B_0C0D;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clock); #1;
         if (la_gnt_o && gntCycle == 0) begin
            gntCycle = c;
            la_req_i = 0;
            assertCount++; if (sram_csb0_o !== 2'b01) begin failCount++; $display("[TB] FAIL la_wr_csb: got %b expected 01", sram_csb0_o); end
            assertCount++; if (sram_web0_o !== 1'b0) begin failCount++; $display("[TB] FAIL la_wr_web: got %b expected 0", sram_web0_o); end
            assertCount++; if (sram_wmask0_o !== 4'hF) begin failCount++; $display("[TB] FAIL la_wr_wmask: got %h expected f", sram_wmask0_o); end
         end
         if (la_rvalid_o) rvSeen++;
      end
      clearInputs();
      assertCount++; if (gntCycle != 1) begin failCount++; $display("[TB] FAIL la_wr_gnt_cycle: got %0d expected 1", gntCycle); end
      assertCount++; if (rvSeen != 0) begin failCount++; $display("[TB] FAIL la_wr_no_rvalid: got %0d pulses expected 0", rvSeen); end
      assertCount++; if (mem[1][9] !== 32'h0A0B_0C0D) begin failCount++; $display("[TB] FAIL la_wr_mem: got %h expected 0a0b0c0d", mem[1][9]); end
   endtask

   task automatic test_sel_zero();
      int ackCycle = 0;
      preload(1'b0, 9'd20, 32'h1111_1111);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h3000_0050; wbs_dat_i = 32'hFFFF_FFFF;
      for (int c = 1; c <= 6 && ackCycle == 0; c++) begin
         @(posedge clock); #1;
         if (c == 1) begin
            assertCount++; if (sram_csb0_o !== 2'b10) begin failCount++; $display("[TB] FAIL sel0_csb: got %b expected 10", sram_csb0_o); end
            assertCount++; if (sram_wmask0_o !== 4'h0) begin failCount++; $display("[TB] FAIL sel0_wmask: got %h expected 0", sram_wmask0_o); end
         end
         if (wbs_ack_o) ackCycle = c;
      end
      clearInputs();
      assertCount++; if (ackCycle != 2) begin failCount++; $display("[TB] FAIL sel0_ack_latency: got %0d expected 2", ackCycle); end
      assertCount++; if (mem[0][20] !== 32'h1111_1111) begin failCount++; $display("[TB] FAIL sel0_mem: got %h expected 11111111", mem[0][20]); end
   endtask

   task automatic test_cyc_drop();
      int ackSeen = 0;
      int issuesBefore;
      @(posedge clock); #1;
      issuesBefore = issueCount;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0010;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clock); #1;
         if (c == 1) clearInputs();
         if (wbs_ack_o) ackSeen++;
      end
      assertCount++; if (ackSeen != 0) begin failCount++; $display("[TB] FAIL cycdrop_no_ack: got %0d acks expected 0", ackSeen); end
      assertCount++; if (issueCount - issuesBefore != 1) begin failCount++; $display("[TB] FAIL cycdrop_access: got %0d csb-low cycles expected 1", issueCount - issuesBefore); end
   endtask

   task automatic test_back_to_back();
      int wbAcks = 0;
      int laGnts = 0;
      int startLen;
      int bothBefore;
      int badOrder = 0;
      resetDut();
      startLen = logLen;
      bothBefore = bothLowCount;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3000_0100; wbs_dat_i = 32'h5555_0000;
      la_req_i = 1; la_we_i = 1; la_adr_i = {1'b1, 9'd100}; la_dat_i = 32'h6666_0000;
      for (int c = 1; c <= 60 && (wbAcks < 4 || laGnts < 4); c++) begin
         @(posedge clock); #1;
         if (wbs_ack_o) begin
            wbAcks++;
            if (wbAcks == 4) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
         end
         if (la_gnt_o) begin
            laGnts++;
            if (laGnts == 4) la_req_i = 0;
         end
      end
      clearInputs();
      repeat (3) @(posedge clock);
      #1;
      assertCount++; if (wbAcks != 4) begin failCount++; $display("[TB] FAIL b2b_wb_acks: got %0d expected 4", wbAcks); end
      assertCount++; if (laGnts != 4) begin failCount++; $display("[TB] FAIL b2b_la_grants: got %0d expected 4", laGnts); end
      assertCount++; if (logLen - startLen != 8) begin failCount++; $display("[TB] FAIL b2b_issue_count: got %0d expected 8", logLen - startLen); end
      for (int i = 0; i < 8 && startLen + i < logLen; i++)
         if (issueLog[startLen + i] !== i[0]) badOrder++;
      assertCount++; if (badOrder != 0) begin failCount++; $display("[TB] FAIL b2b_alternation: got %0d out-of-order grants expected 0", badOrder); end
      assertCount++; if (bothLowCount != bothBefore) begin failCount++; $display("[TB] FAIL b2b_both_csb_low: got %0d cycles expected 0", bothLowCount - bothBefore); end
   endtask

   task automatic test_reset_mid();
      int rvSeen = 0;
      int ackCycle = 0;
      @(posedge clock); #1;
      la_req_i = 1; la_we_i = 0; la_adr_i = {1'b0, 9'd7};
      @(posedge clock); #1;
      assertCount++; if (la_gnt_o !== 1'b1) begin failCount++; $display("[TB] FAIL rstmid_gnt: got %b expected 1", la_gnt_o); end
      la_req_i = 0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      assertCount++; if (sram_csb0_o !== 2'b11) begin failCount++; $display("[TB] FAIL rstmid_csb: got %b expected 11", sram_csb0_o); end
      if (la_rvalid_o) rvSeen++;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         if (la_rvalid_o) rvSeen++;
      end
      assertCount++; if (rvSeen != 0) begin failCount++; $display("[TB] FAIL rstmid_no_rvalid: got %0d pulses expected 0", rvSeen); end
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'h0000_ABCD;
      for (int c = 1; c <= 6 && ackCycle == 0; c++) begin
         @(posedge clock); #1;
         if (wbs_ack_o) ackCycle = c;
      end
      clearInputs();
      assertCount++; if (ackCycle != 2) begin failCount++; $display("[TB] FAIL rstmid_idle_after: got ack cycle %0d expected 2", ackCycle); end
   endtask

`ifdef SRAM_WB_ARB_STATS_EN
   task automatic doWbWrite(input logic [31:0] adr, output bit ok);
      ok = 0;
      @(posedge clock); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_dat_i = adr;
      for (int c = 1; c <= 8 && !ok; c++) begin
         @(posedge clock); #1;
         if (wbs_ack_o) ok = 1;
      end
      clearInputs();
   endtask

   task automatic doLaRead(input logic [9:0] adr, output bit ok);
      ok = 0;
      @(posedge clock); #1;
      la_req_i = 1; la_we_i = 0; la_adr_i = adr;
      for (int c = 1; c <= 10 && !ok; c++) begin
         @(posedge clock); #1;
         if (la_gnt_o) la_req_i = 0;
         if (la_rvalid_o) ok = 1;
      end
      clearInputs();
   endtask

   task automatic test_stats();
      bit ok;
      int doneCount = 0;
      resetDut();
      doWbWrite(32'h3000_0000, ok); doneCount += int'(ok);
      doWbWrite(32'h3000_0004, ok); doneCount += int'(ok);
      doLaRead({1'b0, 9'd1}, ok);   doneCount += int'(ok);
      doWbWrite(32'h3000_0808, ok); doneCount += int'(ok);
      doLaRead({1'b1, 9'd2}, ok);   doneCount += int'(ok);
      @(posedge clock); #1;
      assertCount++; if (doneCount != 5) begin failCount++; $display("[TB] FAIL stats_transfers: got %0d completed expected 5", doneCount); end
      assertCount++; if (wb_grant_cnt_o !== 16'd3) begin failCount++; $display("[TB] FAIL stats_wb_cnt: got %0d expected 3", wb_grant_cnt_o); end
      assertCount++; if (la_grant_cnt_o !== 16'd2) begin failCount++; $display("[TB] FAIL stats_la_cnt: got %0d expected 2", la_grant_cnt_o); end
   endtask
`endif

   initial begin
      $display("[TB] sram_wb_arbiter directed test start");
      test_reset();
      test_wb_write();
      test_wb_read();
      test_out_of_window();
      test_la_read();
      test_la_write();
      test_sel_zero();
      test_cyc_drop();
      test_back_to_back();
      test_reset_mid();
`ifdef SRAM_WB_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
